// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel runtime-programmable clock / clock-enable generator.
//
// Each of NUM_CH channels counts system clocks modulo its active divisor and
// drives a registered divided clock (high for the first active_high cycles of
// each period) and a one-cycle tick at the start of every period. New divisor /
// high-time pairs are written into a per-channel shadow and only take effect
// at that channel's period boundary (or immediately while it is disabled), so
// the output never glitches on reconfiguration.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   ch_en        per-channel enable
//   sync_all     strobe: restart every enabled channel at phase 0
//   cfg_we       configuration write strobe
//   cfg_ch       target channel of the write
//   cfg_div      requested period in clk cycles (>= 2)
//   cfg_high     requested high time in clk cycles (1 .. cfg_div-1)
//   cfg_err      one-cycle pulse after a rejected write
//   cfg_pending  per-channel: shadow config waiting for its boundary
//   clk_out      per-channel divided clock, registered
//   tick         per-channel period-start strobe, registered
module clk_div_multi #(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 16,
  parameter int DEFAULT_DIV  = 100,
  parameter int DEFAULT_HIGH = 50,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_all,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] HIGH_RST = DIV_W'(DEFAULT_HIGH);
  localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);

  logic [31:0] ch_idx;
  logic        cfg_bad;
  logic        cfg_ok;

  // Widen the channel index so an out-of-range channel is detectable even
  // when NUM_CH is not a power of two.
  always_comb begin
    ch_idx  = 32'(cfg_ch);
    cfg_bad = (ch_idx >= 32'(NUM_CH)) || (cfg_div < TWO) ||
              (cfg_high == '0) || (cfg_high >= cfg_div);
    cfg_ok  = cfg_we && !cfg_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && cfg_bad;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] active_div;
    logic [DIV_W-1:0] active_high;
    logic [DIV_W-1:0] shadow_div;
    logic [DIV_W-1:0] shadow_high;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic             pending;
    logic             clk_q;
    logic             tick_q;
    logic             hit;
    logic             wrap;
    logic             apply;

    // A wrap (natural or forced by sync_all) and a disabled channel are both
    // period boundaries where the shadow may be promoted safely.
    always_comb begin
      hit     = cfg_ok && (ch_idx == 32'(i));
      wrap    = ch_en[i] && (sync_all || (cnt == active_div - ONE));
      apply   = wrap || !ch_en[i];
      cnt_nxt = wrap ? '0 : cnt + ONE;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        active_div  <= DIV_RST;
        active_high <= HIGH_RST;
        shadow_div  <= DIV_RST;
        shadow_high <= HIGH_RST;
        cnt         <= DIV_RST - ONE;
        pending     <= 1'b0;
        clk_q       <= 1'b0;
        tick_q      <= 1'b0;
      end else begin
        // Apply uses the pre-edge shadow; a write on the same edge refills
        // the shadow and keeps pending set for the next boundary.
        if (apply) begin
          active_div  <= shadow_div;
          active_high <= shadow_high;
        end
        if (hit) begin
          shadow_div  <= cfg_div;
          shadow_high <= cfg_high;
          pending     <= 1'b1;
        end else if (apply) begin
          pending     <= 1'b0;
        end
        if (ch_en[i]) begin
          cnt    <= cnt_nxt;
          // New period always starts high because every legal high time >= 1.
          clk_q  <= wrap ? 1'b1 : (cnt_nxt < active_high);
          tick_q <= wrap;
        end else begin
          // Park at the last count so the first enabled edge is a wrap.
          cnt    <= shadow_div - ONE;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
        end
      end
    end

    assign clk_out[i]     = clk_q;
    assign tick[i]        = tick_q;
    assign cfg_pending[i] = pending;
  end

endmodule
